// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - Sequential instruction fetch with DEPTH-entry prefetch queue and redirect flush
module fetch_prefetch_queue #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken_e,
    input  logic [ADDR_W-1:0] alu_result_e,
    input  logic              pcsrc_w,
    input  logic [ADDR_W-1:0] result_w,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc8
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] q_data  [DEPTH];
    logic [ADDR_W-1:0] q_pc8   [DEPTH];
    logic [ADDR_W-1:0] af_addr [DEPTH];
    logic [PW-1:0]     q_rd, q_wr, af_rd, af_wr;
    logic [CW-1:0]     count, inflight, drop, inflight_next;
    logic [CW:0]       occupancy;
    logic              redirect, req_fire, pop, push;
    logic [ADDR_W-1:0] target;

    always_comb begin
        redirect       = branch_taken_e | pcsrc_w;
        target         = branch_taken_e ? alu_result_e : result_w;
        target[1:0]    = 2'b00;
        occupancy      = {1'b0, count} + {1'b0, inflight};
        imem_req_valid = rst & ~redirect & (occupancy < (CW+1)'(DEPTH));
        req_fire       = imem_req_valid & imem_req_ready;
        pop            = instr_valid & instr_ready;
        // Stale responses and anything landing in the flush cycle never enter the queue.
        push           = imem_rsp_valid & (drop == '0) & ~redirect;
        inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
    end

    assign imem_req_addr = pc;
    assign instr_valid   = (count != '0);
    assign instr_data    = q_data[q_rd];
    assign instr_pc8     = q_pc8[q_rd];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            af_rd    <= '0;
            af_wr    <= '0;
        end else begin
            inflight <= inflight_next;
            if (req_fire)       af_wr <= af_wr + PW'(1);
            if (imem_rsp_valid) af_rd <= af_rd + PW'(1);
            if (redirect) begin
                pc    <= target;
                count <= '0;
                q_rd  <= '0;
                q_wr  <= '0;
                drop  <= inflight_next;
            end else begin
                if (req_fire)                      pc    <= pc + ADDR_W'(4);
                if (imem_rsp_valid && drop != '0)  drop  <= drop - CW'(1);
                if (push)                          q_wr  <= q_wr + PW'(1);
                if (pop)                           q_rd  <= q_rd + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Address FIFO tracks every accepted request, so it advances on dropped responses too.
    always_ff @(posedge clk) begin
        if (req_fire) af_addr[af_wr] <= pc;
        if (push) begin
            q_data[q_wr] <= imem_rsp_data;
            q_pc8[q_wr]  <= af_addr[af_rd] + ADDR_W'(PC_OFFSET);
        end
    end
endmodule
